// File: rtl/prbs15_top_wrapper.sv
// prbs15_top_wrapper
//   Captures a 4-byte user pattern, replays it n times, then streams
//   PRBS-15 (x^15 + x^14 + 1) bytes forever. A byte-sequence detector
//   watches data_out and raises a sticky flag once it has seen the captured
//   pattern n times in a row.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   data_in   : pattern byte, sampled on the first 4 edges after reset
//   n         : repetition count, sampled on the 4th capture edge
//   data_out  : registered output byte stream (00 during capture)
//   data_flag : registered sticky detector flag
module prbs15_top_wrapper #(
  parameter logic [14:0] SEED = 15'h7FFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic [1:0] n,
  output logic [7:0] data_out,
  output logic       data_flag
);

  typedef enum logic [1:0] {CAPTURE, REPLAY, PRBS} state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      rep_q, rep_d;
  logic [1:0]      n_q;
  logic [3:0][7:0] pat_q;
  logic [14:0]     lfsr_q;
  logic [14:0]     lfsr_nxt;
  logic [7:0]      prbs_byte;
  // High once data_out carries an emitted (replay/PRBS) byte, so the
  // detector never mistakes the idle 00 of capture for pattern data.
  logic            out_vld;

  // Eight LFSR steps in one cycle; first generated bit lands in bit 7.
  function automatic logic [22:0] prbs_step8(input logic [14:0] s);
    logic [14:0] t;
    logic [7:0]  b;
    logic        nb;
    t = s;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      nb       = t[14] ^ t[13];
      b[7-i]   = nb;
      t        = {t[13:0], nb};
    end
    return {t, b};
  endfunction

  assign {lfsr_nxt, prbs_byte} = prbs_step8(lfsr_q);

  // Main FSM: next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q + 2'd1;
    rep_d   = rep_q;
    case (state_q)
      CAPTURE: begin
        if (idx_q == 2'd3) begin
          rep_d   = '0;
          state_d = (n == 2'd0) ? PRBS : REPLAY;
        end
      end
      REPLAY: begin
        if (idx_q == 2'd3) begin
          rep_d = rep_q + 2'd1;
          if (rep_q == n_q - 2'd1) state_d = PRBS;
        end
      end
      default: idx_d = idx_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CAPTURE;
      idx_q    <= '0;
      rep_q    <= '0;
      n_q      <= '0;
      pat_q    <= '0;
      lfsr_q   <= SEED;
      data_out <= 8'h00;
      out_vld  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      out_vld <= (state_q != CAPTURE);
      case (state_q)
        CAPTURE: begin
          pat_q[idx_q] <= data_in;
          if (idx_q == 2'd3) n_q <= n;
          data_out <= 8'h00;
        end
        REPLAY: data_out <= pat_q[idx_q];
        default: begin
          data_out <= prbs_byte;
          lfsr_q   <= lfsr_nxt;
        end
      endcase
    end
  end

  // Detector: k = expected pattern byte index, r = completed repetitions.
  logic [1:0] k_q, k_d, r_q, r_d;
  logic       match;
  logic       flag_d;

  always_comb begin
    k_d    = k_q;
    r_d    = r_q;
    match  = (data_out == pat_q[k_q]);
    if (out_vld) begin
      if (match) begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) r_d = r_q + 2'd1;
      end else begin
        r_d = '0;
        // Resync: the mismatching byte may itself start a new pattern.
        k_d = (data_out == pat_q[0]) ? 2'd1 : 2'd0;
      end
    end
    flag_d = data_flag | (out_vld && (n_q != 2'd0) && (r_d == n_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q       <= '0;
      r_q       <= '0;
      data_flag <= 1'b0;
    end else begin
      k_q       <= k_d;
      r_q       <= r_d;
      data_flag <= flag_d;
    end
  end

endmodule

// File: tb/tb_prbs15_top_wrapper.sv
// Self-checking bench for prbs15_top_wrapper: directed scenarios with
// randomized filler, checked against a sequence-level reference model.
module tb_prbs15_top_wrapper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [1:0] n = 2'd0;
  logic [7:0] data_out;
  logic       data_flag;

  int checks = 0;
  int errors = 0;

  localparam int NREF = 4200;
  logic [7:0] prbs_ref [0:NREF-1];

  prbs15_top_wrapper #(.SEED(15'h7FFF)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .n(n),
    .data_out(data_out), .data_flag(data_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit sequence x[i] = x[i-15] ^ x[i-14], seeded so that x[-1-j] = SEED[j];
  // bytes are taken 8 bits at a time, earliest bit as MSB.
  task automatic build_ref();
    bit q[$];
    logic [14:0] sd;
    logic [7:0] b;
    sd = 15'h7FFF;
    for (int m = 0; m < 15; m++) q.push_back(sd[14-m]);
    for (int i = 0; i < 8*NREF; i++) q.push_back(q[i] ^ q[i+1]);
    for (int j = 0; j < NREF; j++) begin
      b = '0;
      for (int k = 0; k < 8; k++) b[7-k] = q[15 + 8*j + k];
      prbs_ref[j] = b;
    end
  endtask

  // Reset, capture pat (pat[0] = B0) with count nn, then check nbytes past replay.
  task automatic run(input logic [3:0][7:0] pat, input logic [1:0] nn, input int nbytes);
    logic [7:0] exp_d;
    logic       exp_f;
    int last;
    #1 rst = 1'b1;
    #1;
    chk("reset dout", {24'h0, data_out}, 32'h0);
    chk("reset flag", {31'h0, data_flag}, 32'h0);
    @(negedge clk) rst = 1'b0;
    last = 4 + 4*nn + nbytes;
    for (int e = 1; e <= last; e++) begin
      if (e <= 4) data_in = pat[e-1];
      else        data_in = 8'($urandom);
      n = (e == 4) ? nn : 2'($urandom_range(3));
      @(posedge clk);
      @(negedge clk);
      if (e <= 4)            exp_d = 8'h00;
      else if (e <= 4+4*nn)  exp_d = pat[(e-5) % 4];
      else                   exp_d = prbs_ref[e-5-4*nn];
      exp_f = (nn != 2'd0) && (e >= 5 + 4*nn);
      chk($sformatf("dout n%0d E%0d", nn, e), {24'h0, data_out}, {24'h0, exp_d});
      chk($sformatf("flag n%0d E%0d", nn, e), {31'h0, data_flag}, {31'h0, exp_f});
    end
  endtask

  initial begin
    build_ref();
    // Spot-check the model against the known first PRBS bytes.
    chk("ref byte0", {24'h0, prbs_ref[0]}, 32'h00);
    chk("ref byte1", {24'h0, prbs_ref[1]}, 32'h02);

    repeat (2) @(negedge clk);
    chk("por dout", {24'h0, data_out}, 32'h0);
    chk("por flag", {31'h0, data_flag}, 32'h0);

    // Basic replay n=2 with long PRBS check and n toggling after capture
    run({8'hFF, 8'hEE, 8'hDD, 8'hCC}, 2'd2, 4096);

    // Asynchronous reset mid-stream, away from any clock edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst dout", {24'h0, data_out}, 32'h0);
    chk("async rst flag", {31'h0, data_flag}, 32'h0);

    // n = 0: PRBS straight after capture, flag never rises
    run({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 2'd0, 40);

    // n = 3 with repeated bytes
    run({8'hBB, 8'hAA, 8'hAA, 8'hAA}, 2'd3, 20);

    // n = 1 boundary
    run({8'h5A, 8'hA5, 8'h00, 8'h11}, 2'd1, 16);

    // Randomized patterns and counts
    for (int t = 0; t < 6; t++)
      run({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)},
          2'($urandom_range(3)), 24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs15_top_wrapper.md
# prbs15_top_wrapper

Top-level PRBS-15 pattern block. It captures a 4-byte user pattern from `data_in`, replays that pattern `n` times on `data_out`, then streams PRBS-15 bytes indefinitely. An on-chip byte sequence detector monitors `data_out` and raises `data_flag` once it has seen the captured pattern `n` times in a row. The block sits between the test-pattern source and the serializer/link under test.

## Interface

Parameters:
- `SEED`, 15'h7FFF: LFSR value loaded on reset; must be non-zero.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `data_in`  in  8: pattern byte, sampled during the capture phase only.
- `n`  in  2: pattern repetition count (0..3), sampled on the last capture cycle.
- `data_out`  out  8: registered output byte stream.
- `data_flag`  out  1: registered detector flag; sticky until reset.

## Operation

- The main FSM has three states: CAPTURE → REPLAY → PRBS.
- Reset forces the following values:
  - state = CAPTURE, byte index = 0, repetition count = 0;
  - LFSR = SEED;
  - `data_out` = 8'h00, `data_flag` = 0;
  - pattern registers B0..B3 = 0;
  - detector cleared.
- CAPTURE:
  - On each of the first 4 rising edges after reset deassertion, store `data_in` into B0, B1, B2, B3 in order.
  - On the 4th edge, latch `n` into `n_q`.
  - `data_out` holds 8'h00 throughout.
- REPLAY:
  - Emit B0, B1, B2, B3 on `data_out`, and repeat this `n_q` times in total.
  - If `n_q` = 0, skip REPLAY and go straight to PRBS.
- PRBS:
  - The LFSR is 15 bits, polynomial x^15 + x^14 + 1.
  - Each step computes `new = s[14] ^ s[13]`, then `s <= {s[13:0], new}`. `new` is the output bit.
  - Each output byte takes 8 consecutive steps, computed in one cycle. The first bit goes to bit 7 and the last bit to bit 0.
  - The LFSR advances only in PRBS.
  - PRBS continues forever; only reset leaves this state.
- Detector (independent FSM):
  - Watches the registered `data_out` stream against B0..B3, with byte index `k` (0..3) and completed-repetition count `r`.
  - If `data_out` == B[k]: advance `k`. When `k` wraps from 3 to 0, increment `r`.
  - On a mismatch: set `r` = 0. If `data_out` == B0, set `k` = 1; otherwise set `k` = 0.
  - When `r` reaches `n_q`, with `n_q` ≠ 0, set `data_flag` = 1. The flag stays 1 until reset.
  - When `n_q` = 0, `data_flag` never asserts.
  - The detector is active only once the main FSM has left CAPTURE.
  - A pattern that naturally continues matching in PRBS does not matter, because the flag is sticky.
- Reset mid-operation: all state returns immediately, asynchronously, to the reset values listed above, and capture restarts.

## Timing

- Let edge E1 be the first rising edge with `rst` low.
- Edges E1..E4 capture B0..B3.
- After E5, `data_out` = B0. After E(4+4·n_q), `data_out` = B3 of the last repetition.
- After E(5+4·n_q), `data_out` holds the first PRBS byte.
- `data_flag` rises on the edge after the last B3 of repetition `n_q` is presented, which is E(5+4·n_q).
- With `n_q` = 0, the first PRBS byte appears after E5.
- With SEED = 7FFF, the first PRBS bytes are 8'h00 and then 8'h02.
- All outputs are glitch-free registers. There is no handshake, and one byte is produced per cycle after capture.

## Test plan

- **Reset**: assert `rst` mid-stream → `data_out` = 00 and `data_flag` = 0 immediately, without waiting for a clock edge. After deassert, capture restarts at B0.
- **Basic replay, n = 2**: drive CC, DD, EE, FF on E1..E4 → `data_out` = CC DD EE FF CC DD EE FF. `data_flag` = 1 from E13 onward.
- **PRBS start, n = 2, SEED = 7FFF**: bytes after the replay are 00, 02, … and match a bit-serial reference model of x^15 + x^14 + 1 for at least 4096 bytes. The period of the bit sequence is 32767.
- **n = 0**: first PRBS byte after E5, and `data_flag` stays 0 for the whole run.
- **n = 3 with repeated bytes**: pattern AA, AA, AA, BB → exactly 12 replay bytes, then `data_flag` rises at E17. This checks the detector's resync handling on repeated bytes.
- **n changes after capture**: change `n` after E4 → it has no effect on the replay count.
